// File: rtl/and_gate.sv
// Bitwise AND cell with combinational and registered results, an all-high flag and a
// saturating rise-event counter. Define AND_GATE_FILTER_EN to add a stability filter in front of y_q.
module and_gate #(
    parameter int unsigned WIDTH      = 1,
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned FILTER_LEN = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] y_q,
    output logic             all_high,
    output logic [CNT_W-1:0] edge_cnt
);

    // Elaboration-time parameter sanity checks
    if (WIDTH < 1)      begin : g_bad_width  $error("and_gate: WIDTH must be >= 1");      end
    if (CNT_W < 1)      begin : g_bad_cnt_w  $error("and_gate: CNT_W must be >= 1");      end
    if (FILTER_LEN < 1) begin : g_bad_filter $error("and_gate: FILTER_LEN must be >= 1"); end

    logic [WIDTH-1:0] y_q_next;
    logic             rise;

    assign y = a & b;

`ifdef AND_GATE_FILTER_EN
    localparam int unsigned STAB_W = $clog2(FILTER_LEN + 1);

    logic [WIDTH-1:0]  cand;
    logic [STAB_W-1:0] stab;
    logic [STAB_W-1:0] stab_next;

    // A new sample value restarts the run at one; y_q follows only after a full run
    always_comb begin
        stab_next = stab;
        y_q_next  = y_q;
        if (y != cand) begin
            stab_next = STAB_W'(1);
        end else if (stab < STAB_W'(FILTER_LEN)) begin
            stab_next = stab + STAB_W'(1);
        end
        if (stab_next >= STAB_W'(FILTER_LEN)) begin
            y_q_next = y;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cand <= '0;
            stab <= '0;
        end else begin
            cand <= y;
            stab <= stab_next;
        end
    end
`else
    assign y_q_next = y;
`endif

    // Any bit going 0->1 on this edge is a single rise event
    assign rise = |(y_q_next & ~y_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_q      <= '0;
            edge_cnt <= '0;
        end else begin
            y_q <= y_q_next;
            if (rise && (edge_cnt != {CNT_W{1'b1}})) begin
                edge_cnt <= edge_cnt + CNT_W'(1);
            end
        end
    end

    assign all_high = &y_q;

endmodule

// File: tb/tb_and_gate.sv
// Scoreboard bench for and_gate: driver pushes expected registered outputs from a
// sample-history reference model, a monitor pops and compares after each rising edge.
module tb_and_gate;

    localparam int unsigned W    = 4;
    localparam int unsigned CW   = 3;
    localparam int unsigned FL   = 2;
    localparam int          MAXC = (1 << CW) - 1;

    typedef struct {
        logic [W-1:0] yq;
        logic         ah;
        int           cnt;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [W-1:0]  y;
    logic [W-1:0]  y_q;
    logic          all_high;
    logic [CW-1:0] edge_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    exp_t          sb[$];
    logic [W-1:0]  hist[$];
    logic [W-1:0]  m_yq;
    int            m_cnt;

    and_gate #(.WIDTH(W), .CNT_W(CW), .FILTER_LEN(FL)) dut (
        .clk      (clk),
        .rst      (rst),
        .a        (a),
        .b        (b),
        .y        (y),
        .y_q      (y_q),
        .all_high (all_high),
        .edge_cnt (edge_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_yq  = '0;
        m_cnt = 0;
        hist.delete();
    endfunction

    // One clock edge of the reference: returns nothing, pushes the expected post-edge state
    function automatic void model_step(input logic [W-1:0] s);
        logic [W-1:0] nxt;
        bit           stable;
        exp_t         e;
        nxt = s;
`ifdef AND_GATE_FILTER_EN
        hist.push_back(s);
        if (hist.size() > FL) void'(hist.pop_front());
        stable = (hist.size() == FL);
        foreach (hist[i]) if (hist[i] != s) stable = 0;
        nxt = stable ? s : m_yq;
`else
        stable = 1;
`endif
        if (stable && ((nxt & ~m_yq) != '0) && (m_cnt < MAXC)) m_cnt = m_cnt + 1;
        m_yq   = nxt;
        e.yq   = m_yq;
        e.ah   = (m_yq == {W{1'b1}});
        e.cnt  = m_cnt;
        sb.push_back(e);
    endfunction

    task automatic drive(input logic [W-1:0] av, input logic [W-1:0] bv, input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            a = av;
            b = bv;
            #1;
            check("y_comb", y, av & bv);
            model_step(av & bv);
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("rst_y_q", y_q, 0);
        check("rst_all_high", all_high, 0);
        check("rst_edge_cnt", edge_cnt, 0);
        check("rst_y_kept", y, a & b);
        model_reset();
        rst = 1'b0;
        model_step(a & b);
    endtask

    // Monitor: compares registered outputs after every edge that has an expectation
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("y_q", y_q, e.yq);
                check("all_high", all_high, e.ah);
                check("edge_cnt", edge_cnt, e.cnt);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d checks", n_checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        a   = '0;
        b   = '0;
        model_reset();
        #1;
        check("init_y_q", y_q, 0);
        check("init_all_high", all_high, 0);
        check("init_edge_cnt", edge_cnt, 0);
        @(negedge clk);
        rst = 1'b0;
        model_step(a & b);

        // Truth table: each bit sees all four operand combinations
        drive(4'b0101, 4'b0011, 10);
        drive(4'h0, 4'h0, 10);
        drive(4'hF, 4'h0, 10);
        drive(4'h0, 4'hF, 10);
        drive(4'hF, 4'hF, 10);
        drive(4'hC, 4'h6, 3);

        // Latency: a high, b goes high
        drive(4'hF, 4'h0, 3);
        drive(4'hF, 4'hF, 3);

        // Glitches and held pulses on b, driving the counter into saturation
        for (int i = 0; i < 3; i++) begin
            drive(4'hF, 4'h0, 2);
            drive(4'hF, 4'hF, 1);
        end
        for (int i = 0; i < 10; i++) begin
            drive(4'hF, 4'h0, FL);
            drive(4'hF, 4'hF, FL);
        end
        @(negedge clk);
        check("edge_cnt_saturated", edge_cnt, MAXC);

        // Asynchronous reset between edges with y_q high
        pulse_reset();
        drive(4'hF, 4'hF, 3);
        drive(4'h0, 4'h0, 2);
        drive(4'h1, 4'h1, 3);
        pulse_reset();

        // Randomized operands, each held 1..3 edges
        for (int i = 0; i < 150; i++) begin
            logic [W-1:0] ra, rb;
            ra = W'($urandom);
            rb = W'($urandom);
            if ($urandom_range(0, 3) == 0) ra = '1;
            if ($urandom_range(0, 3) == 0) rb = '1;
            drive(ra, rb, $urandom_range(1, 3));
            if ($urandom_range(0, 40) == 0) pulse_reset();
        end

        repeat (3) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
